// File: rtl/log_mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// log_mac_dot_sequencer
//
// Drives a single log-domain multiply / float-accumulate processing element
// (PE) through complete dot products. A command carries the dot-product
// length N. The sequencer then streams N operand pairs into the PE, asserting
// peClear with the first pair so the PE starts from +0. After the last pair
// it waits out the PE pipeline, captures the PE accumulator and holds it on a
// valid/ready result port until the result is taken.
//
// Ports
//   clock, resetN          rising-edge clock, async active-low reset
//   cmdValid/cmdReady      command handshake, cmdLen = number of pairs (0 ok)
//   inValid/inReady        operand-pair handshake, aIn/bIn packed log words
//   peA, peB, peClear      registered operand/clear drive into the PE
//   peAcc                  PE accumulator register output
//   outValid/outReady      result handshake, outData = final accumulator word
//   busy                   high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module log_mac_dot_sequencer #(
    parameter int EXP      = 8,
    parameter int FRAC     = 7,
    parameter int ACC_EXP  = 8,
    parameter int ACC_FRAC = 7,
    parameter int LEN_BITS = 16,
    parameter int PE_LAT   = 2
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic                          cmdValid,
    output logic                          cmdReady,
    input  logic [LEN_BITS-1:0]           cmdLen,
    input  logic                          inValid,
    output logic                          inReady,
    input  logic [EXP+FRAC:0]             aIn,
    input  logic [EXP+FRAC:0]             bIn,
    output logic [EXP+FRAC:0]             peA,
    output logic [EXP+FRAC:0]             peB,
    output logic                          peClear,
    input  logic [ACC_EXP+ACC_FRAC:0]     peAcc,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [ACC_EXP+ACC_FRAC:0]     outData,
    output logic                          busy
);

    localparam int OP_W    = 1 + EXP + FRAC;
    localparam int ACC_W   = 1 + ACC_EXP + ACC_FRAC;
    localparam int DRAIN_W = $clog2(PE_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t               state_q,      state_d;
    logic [LEN_BITS-1:0]  remaining_q,  remaining_d;
    logic [DRAIN_W-1:0]   drain_cnt_q,  drain_cnt_d;
    logic                 first_pair_q, first_pair_d;
    logic [OP_W-1:0]      pe_a_q,       pe_a_d;
    logic [OP_W-1:0]      pe_b_q,       pe_b_d;
    logic                 pe_clear_q,   pe_clear_d;
    logic                 out_valid_q,  out_valid_d;
    logic [ACC_W-1:0]     out_data_q,   out_data_d;
    logic                 busy_q,       busy_d;

    logic cmd_fire;
    logic in_fire;
    logic out_fire;

    // Handshake readies are decoded straight from the state so a command or
    // pair can be accepted in the same cycle the state is entered.
    assign cmdReady = (state_q == ST_IDLE);
    assign inReady  = (state_q == ST_FEED);

    assign cmd_fire = cmdValid & cmdReady;
    assign in_fire  = inValid  & inReady;
    assign out_fire = out_valid_q & outReady;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state_q;
        remaining_d  = remaining_q;
        drain_cnt_d  = drain_cnt_q;
        first_pair_d = first_pair_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        // The PE sees +0 operands and no clear unless a pair is issued, so
        // idle and bubble cycles add nothing to the accumulator.
        pe_a_d       = '0;
        pe_b_d       = '0;
        pe_clear_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    remaining_d = cmdLen;
                    if (cmdLen != '0) begin
                        first_pair_d = 1'b1;
                        state_d      = ST_FEED;
                    end else begin
                        // Empty dot product: answer +0 without touching the PE.
                        out_data_d  = '0;
                        out_valid_d = 1'b1;
                        state_d     = ST_OUT;
                    end
                end
            end

            ST_FEED: begin
                if (in_fire) begin
                    pe_a_d       = aIn;
                    pe_b_d       = bIn;
                    pe_clear_d   = first_pair_q;
                    first_pair_d = 1'b0;
                    remaining_d  = remaining_q - LEN_BITS'(1);
                    if (remaining_q == LEN_BITS'(1)) begin
                        drain_cnt_d = DRAIN_W'(PE_LAT);
                        state_d     = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                // On the final drain cycle the accumulator register already
                // holds the contribution of the last issued pair.
                if (drain_cnt_q == DRAIN_W'(1)) begin
                    out_data_d  = peAcc;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end

            ST_OUT: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: the asynchronous reset clears every register, including the
    // datapath words, so a reset mid-product leaves nothing stale on the
    // PE drive or the result port.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            drain_cnt_q  <= '0;
            first_pair_q <= 1'b0;
            pe_a_q       <= '0;
            pe_b_q       <= '0;
            pe_clear_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed for this cycle, independent of statement order.
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            drain_cnt_q  <= drain_cnt_d;
            first_pair_q <= first_pair_d;
            pe_a_q       <= pe_a_d;
            pe_b_q       <= pe_b_d;
            pe_clear_q   <= pe_clear_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
        end
    end

    assign peA      = pe_a_q;
    assign peB      = pe_b_q;
    assign peClear  = pe_clear_q;
    assign outValid = out_valid_q;
    assign outData  = out_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_log_mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_log_mac_dot_sequencer
//
// Directed bench for log_mac_dot_sequencer with a small behavioural PE that
// multiplies and accumulates in real arithmetic (values are exact for the
// small powers-of-two sums used here). The PE has one accumulator register
// fed directly by peA/peB/peClear, so a pair registered by the sequencer
// reaches peAcc within PE_LAT = 2 cycles of its fire. The PE accumulator is
// never reset, so a stale value must be overridden by peClear.
// ---------------------------------------------------------------------------
module tb_log_mac_dot_sequencer;

    localparam int W = 16;
    localparam logic [W-1:0] F_ZERO = 16'h0000;
    localparam logic [W-1:0] F_ONE  = 16'h3F80;
    localparam logic [W-1:0] F_TWO  = 16'h4000;
    localparam logic [W-1:0] F_FOUR = 16'h4080;

    logic          clock;
    logic          resetN;
    logic          cmdValid;
    logic          cmdReady;
    logic [15:0]   cmdLen;
    logic          inValid;
    logic          inReady;
    logic [W-1:0]  aIn;
    logic [W-1:0]  bIn;
    logic [W-1:0]  peA;
    logic [W-1:0]  peB;
    logic          peClear;
    logic [W-1:0]  peAcc = '0;
    logic          outValid;
    logic          outReady;
    logic [W-1:0]  outData;
    logic          busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    log_mac_dot_sequencer #(
        .EXP(8), .FRAC(7), .ACC_EXP(8), .ACC_FRAC(7), .LEN_BITS(16), .PE_LAT(2)
    ) dut (
        .clock    (clock),
        .resetN   (resetN),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .cmdLen   (cmdLen),
        .inValid  (inValid),
        .inReady  (inReady),
        .aIn      (aIn),
        .bIn      (bIn),
        .peA      (peA),
        .peB      (peB),
        .peClear  (peClear),
        .peAcc    (peAcc),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .busy     (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- behavioural PE ----------------
    function automatic real w2r(input logic [W-1:0] w);
        real v;
        int  e;
        if (w[14:7] == 8'd0) return 0.0;
        v = 1.0 + real'(w[6:0]) / 128.0;
        e = int'(w[14:7]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return w[15] ? -v : v;
    endfunction

    function automatic logic [W-1:0] r2w(input real r);
        real        v;
        int         e;
        logic       s;
        logic [6:0] f;
        if (r == 0.0) return '0;
        s = (r < 0.0);
        v = s ? -r : r;
        e = 127;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        f = 7'($rtoi((v - 1.0) * 128.0));
        return {s, 8'(e), f};
    endfunction

    real pe_prod_r;
    real pe_sum_r;
    always @(posedge clock) begin
        pe_prod_r = w2r(peA) * w2r(peB);
        pe_sum_r  = peClear ? pe_prod_r : (w2r(peAcc) + pe_prod_r);
        peAcc    <= r2w(pe_sum_r);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] len);
        cmdValid = 1'b1;
        cmdLen   = len;
        step();
        cmdValid = 1'b0;
    endtask

    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        inValid = 1'b1;
        aIn     = a;
        bIn     = b;
        step();
        inValid = 1'b0;
        aIn     = '0;
        bIn     = '0;
    endtask

    // Waits (bounded) for outValid; cycles = -1 on timeout.
    task automatic wait_out(output int cycles, output logic [W-1:0] data);
        int c;
        c = 0;
        while (outValid !== 1'b1 && c < 20) begin
            step();
            c++;
        end
        cycles = (outValid === 1'b1) ? c : -1;
        data   = outData;
    endtask

    task automatic take_result();
        outReady = 1'b1;
        step();
        outReady = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetN = 1'b0;
        step();
        step();
        total_cnt++;
        if ({cmdReady, inReady, outValid, busy, peClear} !== 5'b10000) begin
            $display("FAIL reset_flags: got {cmdReady,inReady,outValid,busy,peClear}=%b expected 10000",
                     {cmdReady, inReady, outValid, busy, peClear});
        end else pass_cnt++;
        total_cnt++;
        if ({peA, peB, outData} !== 48'h0) begin
            $display("FAIL reset_data: got peA=%h peB=%h outData=%h expected all 0", peA, peB, outData);
        end else pass_cnt++;
        resetN = 1'b1;
        step();
    endtask

    task automatic test_continuous();
        int          cyc;
        logic [W-1:0] d;
        send_cmd(16'd4);
        total_cnt++;
        if ({busy, inReady, cmdReady} !== 3'b110) begin
            $display("FAIL cont_feed_state: got {busy,inReady,cmdReady}=%b expected 110",
                     {busy, inReady, cmdReady});
        end else pass_cnt++;
        send_pair(F_ONE, F_ONE);
        total_cnt++;
        if (peClear !== 1'b1 || peA !== F_ONE || peB !== F_ONE) begin
            $display("FAIL cont_first_pair: got clear=%b a=%h b=%h expected 1 3f80 3f80", peClear, peA, peB);
        end else pass_cnt++;
        send_pair(F_ONE, F_ONE);
        total_cnt++;
        if (peClear !== 1'b0) begin
            $display("FAIL cont_second_clear: got %b expected 0", peClear);
        end else pass_cnt++;
        send_pair(F_ONE, F_ONE);
        send_pair(F_ONE, F_ONE);
        total_cnt++;
        if (inReady !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL cont_drain_state: got inReady=%b busy=%b expected 0 1", inReady, busy);
        end else pass_cnt++;
        wait_out(cyc, d);
        total_cnt++;
        if (cyc !== 2) begin
            $display("FAIL cont_latency: got %0d cycles after last-pair edge expected 2", cyc);
        end else pass_cnt++;
        total_cnt++;
        if (d !== F_FOUR) begin
            $display("FAIL cont_result: got %h expected %h", d, F_FOUR);
        end else pass_cnt++;
        take_result();
        total_cnt++;
        if ({outValid, cmdReady, busy} !== 3'b010) begin
            $display("FAIL cont_after_fire: got {outValid,cmdReady,busy}=%b expected 010",
                     {outValid, cmdReady, busy});
        end else pass_cnt++;
    endtask

    task automatic test_bubbles();
        int          cyc;
        logic [W-1:0] d;
        int          gap_bad;
        send_cmd(16'd2);
        send_pair(F_ONE, F_ONE);
        gap_bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (peA !== F_ZERO || peB !== F_ZERO || peClear !== 1'b0 || inReady !== 1'b1) gap_bad++;
        end
        total_cnt++;
        if (gap_bad != 0) begin
            $display("FAIL bubble_gap_drive: got %0d bad gap cycles (last a=%h b=%h clear=%b) expected 0",
                     gap_bad, peA, peB, peClear);
        end else pass_cnt++;
        send_pair(F_ONE, F_ONE);
        total_cnt++;
        if (peClear !== 1'b0 || peA !== F_ONE) begin
            $display("FAIL bubble_second_pair: got clear=%b a=%h expected 0 3f80", peClear, peA);
        end else pass_cnt++;
        wait_out(cyc, d);
        total_cnt++;
        if (cyc !== 2 || d !== F_TWO) begin
            $display("FAIL bubble_result: got %h after %0d cycles expected %h after 2", d, cyc, F_TWO);
        end else pass_cnt++;
        take_result();
    endtask

    task automatic test_back_to_back();
        int          cyc;
        logic [W-1:0] d;
        send_cmd(16'd1);
        send_pair(F_TWO, F_ONE);
        wait_out(cyc, d);
        total_cnt++;
        if (d !== F_TWO) begin
            $display("FAIL b2b_first: got %h expected %h", d, F_TWO);
        end else pass_cnt++;
        take_result();
        total_cnt++;
        if (cmdReady !== 1'b1) begin
            $display("FAIL b2b_idle_gap: got cmdReady=%b expected 1", cmdReady);
        end else pass_cnt++;
        send_cmd(16'd1);
        send_pair(F_ONE, F_ONE);
        total_cnt++;
        if (peClear !== 1'b1) begin
            $display("FAIL b2b_clear: got %b expected 1", peClear);
        end else pass_cnt++;
        wait_out(cyc, d);
        total_cnt++;
        if (cyc !== 2 || d !== F_ONE) begin
            $display("FAIL b2b_second: got %h after %0d cycles expected %h after 2", d, cyc, F_ONE);
        end else pass_cnt++;
        take_result();
    endtask

    task automatic test_zero_len();
        int clear_seen;
        send_cmd(16'd0);
        clear_seen = int'(peClear);
        total_cnt++;
        if (outValid !== 1'b1 || outData !== F_ZERO || busy !== 1'b1 || inReady !== 1'b0) begin
            $display("FAIL zero_len_result: got valid=%b data=%h busy=%b inReady=%b expected 1 0000 1 0",
                     outValid, outData, busy, inReady);
        end else pass_cnt++;
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        clear_seen += int'(peClear);
        total_cnt++;
        if (clear_seen != 0 || outValid !== 1'b0 || cmdReady !== 1'b1) begin
            $display("FAIL zero_len_done: got clear_seen=%0d valid=%b cmdReady=%b expected 0 0 1",
                     clear_seen, outValid, cmdReady);
        end else pass_cnt++;
    endtask

    task automatic test_hold();
        int          cyc;
        logic [W-1:0] d;
        int          hold_bad;
        send_cmd(16'd1);
        send_pair(F_ONE, F_ONE);
        wait_out(cyc, d);
        cmdValid = 1'b1;
        cmdLen   = 16'd1;
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (outValid !== 1'b1 || outData !== F_ONE || cmdReady !== 1'b0 || inReady !== 1'b0) hold_bad++;
        end
        total_cnt++;
        if (hold_bad != 0) begin
            $display("FAIL hold_out: got %0d bad cycles (valid=%b data=%h cmdReady=%b) expected 0",
                     hold_bad, outValid, outData, cmdReady);
        end else pass_cnt++;
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        total_cnt++;
        if (cmdReady !== 1'b1 || outValid !== 1'b0) begin
            $display("FAIL hold_release: got cmdReady=%b valid=%b expected 1 0", cmdReady, outValid);
        end else pass_cnt++;
        step();
        cmdValid = 1'b0;
        total_cnt++;
        if (inReady !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL hold_cmd_accept: got inReady=%b busy=%b expected 1 1", inReady, busy);
        end else pass_cnt++;
        send_pair(F_ONE, F_ONE);
        wait_out(cyc, d);
        total_cnt++;
        if (d !== F_ONE) begin
            $display("FAIL hold_next_result: got %h expected %h", d, F_ONE);
        end else pass_cnt++;
        take_result();
    endtask

    task automatic test_reset_mid_feed();
        int          cyc;
        logic [W-1:0] d;
        int          stray;
        send_cmd(16'd4);
        send_pair(F_TWO, F_ONE);
        send_pair(F_TWO, F_ONE);
        resetN = 1'b0;
        #1;
        total_cnt++;
        if ({cmdReady, inReady, outValid, busy, peClear} !== 5'b10000 || peA !== F_ZERO || peB !== F_ZERO) begin
            $display("FAIL midreset_outputs: got flags=%b peA=%h peB=%h expected 10000 0000 0000",
                     {cmdReady, inReady, outValid, busy, peClear}, peA, peB);
        end else pass_cnt++;
        step();
        resetN = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (outValid !== 1'b0 || busy !== 1'b0) stray++;
        end
        total_cnt++;
        if (stray != 0) begin
            $display("FAIL midreset_no_result: got %0d cycles with valid/busy expected 0", stray);
        end else pass_cnt++;
        send_cmd(16'd1);
        send_pair(F_ONE, F_ONE);
        wait_out(cyc, d);
        total_cnt++;
        if (cyc !== 2 || d !== F_ONE) begin
            $display("FAIL midreset_next: got %h after %0d cycles expected %h after 2", d, cyc, F_ONE);
        end else pass_cnt++;
        take_result();
    endtask

    initial begin
        resetN   = 1'b0;
        cmdValid = 1'b0;
        cmdLen   = '0;
        inValid  = 1'b0;
        aIn      = '0;
        bIn      = '0;
        outReady = 1'b0;

        test_reset();
        test_continuous();
        test_bubbles();
        test_back_to_back();
        test_zero_len();
        test_hold();
        test_reset_mid_feed();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
